// File: rtl/cnu_pkg.sv
// Shared helpers for the min-sum check-node datapath.
// Ports: none (package). Provides clog2, offset_sat and the sign-magnitude
// convention: a message is {sign, magnitude}, sign in the MSB, 1 = negative.
package cnu_pkg;

  // Ceiling log2 for sizing counters from a degree; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Offset subtraction with a floor of zero. Operands are zero-extended to
  // 32 bits by the caller; the result never exceeds m, so truncating it back
  // to the magnitude width is lossless.
  function automatic logic [31:0] offset_sat(input logic [31:0] m,
                                              input logic [31:0] off);
    return (m > off) ? (m - off) : 32'd0;
  endfunction

  // Zero magnitudes always carry a positive sign so there is a single
  // encoding of zero on the wire.
  function automatic logic canon_sign(input logic s, input logic nonzero);
    return s & nonzero;
  endfunction

endpackage

// File: rtl/cnu_offset_sat.sv
// Single-edge offset-min-sum message conversion (combinational).
// Ports: m = selected magnitude, sgn = raw edge sign,
//        msg = {canonical sign, max(m - OFFSET, 0)}.
module cnu_offset_sat
  import cnu_pkg::*;
#(
  parameter int          data_w = 8,
  parameter int unsigned OFFSET = 1
) (
  input  logic [data_w-1:0] m,
  input  logic              sgn,
  output logic [data_w:0]   msg
);

  logic [data_w-1:0] mag;

  always_comb begin
    mag = data_w'(offset_sat(32'(m), 32'(OFFSET)));
    msg = {canon_sign(sgn, mag != '0), mag};
  end

endmodule

// File: rtl/cnu_msg_gen.sv
// Check-node output stage: accepts one {min, min2, min_idx, signs} frame and
// serialises D offset-min-sum check-to-variable messages, one edge per beat.
// Ports: clk/rst (sync, active-high); in_valid/in_ready frame handshake with
//        min, min2, min_idx, signs; out_valid/out_ready message handshake with
//        out_data ({sign, mag}), out_idx (edge k) and out_last (k == D-1).
module cnu_msg_gen
  import cnu_pkg::*;
#(
  parameter int          data_w = 8,
  parameter int          idx_w  = 8,
  parameter int          D      = 5,
  parameter int unsigned OFFSET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] min,
  input  logic [data_w-1:0] min2,
  input  logic [idx_w-1:0]  min_idx,
  input  logic [D-1:0]      signs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w:0]   out_data,
  output logic [idx_w-1:0]  out_idx,
  output logic              out_last
);

  localparam int                cnt_w  = clog2(D);
  localparam logic [cnt_w-1:0]  k_last = cnt_w'(D - 1);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t            state, state_nxt;
  logic [cnt_w-1:0]  k, k_nxt;

  // Held frame.
  logic [data_w-1:0] min_q, min2_q;
  logic [idx_w-1:0]  min_idx_q;
  logic [D-1:0]      signs_q;
  logic              par_q;

  // Frame as it will look after this edge: the bus on accept, else the hold.
  logic [data_w-1:0] min_n, min2_n;
  logic [idx_w-1:0]  min_idx_n;
  logic [D-1:0]      signs_n;
  logic              par_n;

  logic              accept, beat, last_beat;
  logic [data_w-1:0] m_sel;
  logic              sgn_sel;
  logic [data_w:0]   msg;

  assign out_valid = (state == EMIT);

  // Handshake and FSM next state. in_ready opens on the final beat so the
  // next frame can follow without an idle cycle.
  always_comb begin
    beat      = out_valid && out_ready;
    last_beat = beat && out_last;
    in_ready  = (state == IDLE) || last_beat;
    accept    = in_valid && in_ready;

    state_nxt = state;
    k_nxt     = k;
    if (accept) begin
      state_nxt = EMIT;
      k_nxt     = '0;
    end else if (last_beat) begin
      state_nxt = IDLE;
      k_nxt     = '0;
    end else if (beat) begin
      k_nxt     = k + cnt_w'(1);
    end
  end

  // Outputs are registered, so the edge to present next is computed from
  // the next-state counter and the next-state frame.
  always_comb begin
    min_n     = accept ? min     : min_q;
    min2_n    = accept ? min2    : min2_q;
    min_idx_n = accept ? min_idx : min_idx_q;
    signs_n   = accept ? signs   : signs_q;
    par_n     = accept ? ^signs  : par_q;

    // A min_idx outside 0..D-1 (merge-tree pad index) never matches.
    m_sel   = (32'(k_nxt) == 32'(min_idx_n)) ? min2_n : min_n;
    sgn_sel = par_n ^ signs_n[k_nxt];
  end

  cnu_offset_sat #(
    .data_w (data_w),
    .OFFSET (OFFSET)
  ) u_sat (
    .m   (m_sel),
    .sgn (sgn_sel),
    .msg (msg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      min_q     <= '0;
      min2_q    <= '0;
      min_idx_q <= '0;
      signs_q   <= '0;
      par_q     <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (accept) begin
        min_q     <= min;
        min2_q    <= min2;
        min_idx_q <= min_idx;
        signs_q   <= signs;
        par_q     <= ^signs;
      end
      // Under backpressure k_nxt and the frame are unchanged, so the
      // reloaded values equal the held ones.
      if (state_nxt == EMIT) begin
        out_data <= msg;
        out_idx  <= idx_w'(k_nxt);
        out_last <= (k_nxt == k_last);
      end else begin
        out_data <= '0;
        out_idx  <= '0;
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cnu_msg_gen.md
Name: cnu_msg_gen

Overview:
- Check-node output stage of the min-sum CNU. Sits directly downstream of the pipelined min/min2 merge tree.
- Each accepted frame carries {min, min2, min_idx} plus the D sign bits of the incoming variable-to-check messages.
- The block serialises D offset-min-sum check-to-variable messages, one edge per cycle, to the VNU write-back path under a valid/ready handshake.

Parameters:
- data_w, 8, magnitude width of min/min2 and of the output magnitude
- idx_w, 8, width of min_idx and out_idx
- D, 5, check-node degree (edges per frame); D >= 2
- OFFSET, 1, offset subtracted from magnitudes; unsigned, width data_w

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  frame present on input bus
- in_ready  out  1  block accepts a frame this cycle
- min  in  data_w  smallest incoming magnitude
- min2  in  data_w  second-smallest incoming magnitude
- min_idx  in  idx_w  edge index of min
- signs  in  D  sign bit per edge; bit k belongs to edge k; 1 means negative
- out_valid  out  1  out_data/out_idx valid
- out_ready  in  1  downstream accepts this cycle
- out_data  out  data_w+1  sign-magnitude message; MSB is the sign
- out_idx  out  idx_w  edge index k of out_data
- out_last  out  1  high when out_idx == D-1

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: out_valid=0, out_data=0, out_idx=0, out_last=0, internal state=IDLE, counter=0. in_ready=1 in the cycle after reset.
- Input handshake: a frame is accepted on a rising edge where in_valid && in_ready. On acceptance the block registers min, min2, min_idx and signs. It also registers par = XOR of all D sign bits.
- FSM states: IDLE and EMIT.
  - IDLE -> EMIT on accept; counter k=0.
  - In EMIT, each out_valid && out_ready advances k.
  - On a handshake with k==D-1: go to EMIT with k=0 if a new frame is accepted in the same cycle; otherwise go to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is combinational from state and out_ready, and allows back-to-back frames with no bubble.
- Latency: frame accepted at edge t; edge 0 is presented from edge t; D beats complete in D cycles with out_ready held high.
- out_valid = (state==EMIT).
- Per-edge magnitude: m = (k == min_idx) ? min2 : min.
  - mag = (m > OFFSET) ? m - OFFSET : 0, saturating at 0.
  - No wrap-around.
- Per-edge sign: s = par ^ signs[k]. If mag==0, s is forced to 0 (canonical zero).
- out_data = {s, mag}; out_idx = k zero-extended to idx_w; out_last = (k==D-1).
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_last hold stable and k does not advance.
- Outputs are registered. out_data, out_idx and out_last are computed from next-state k and loaded on the edge.
- If min_idx >= D (e.g. the merge tree's odd-D pad index D), no edge matches, and every edge uses min.
- Frame registers load only on accept. A held frame is never corrupted by in_valid toggling.
- rst during EMIT: the frame is discarded; the next cycle shows the reset values above.
- Counter width: clog2(D), computed by a constant function.

Decomposition:
- Shared package cnu_pkg:
  - constant function clog2
  - function offset_sat(m, OFFSET), data_w-wide subtract with floor 0
  - the sign-magnitude packing convention (sign MSB)
- One natural sub-module: cnu_offset_sat, combinational mag/sign computation for a single edge, reused by the VNU-side message conversion.
- FSM, counter and frame registers stay in cnu_msg_gen.

Test Plan:
- Basic frame: D=5, data_w=8, OFFSET=1; min=3, min2=7, min_idx=2, signs=5'b00101 (par=0), out_ready=1.
  - Required: k0..k4 = {1,2},{0,2},{1,6},{0,2},{0,2}, given as {sign,mag}.
  - out_last only on k4; in_ready returns to 1 on the k4 beat.
- Offset floor and zero sign: min=0, min2=5, min_idx=3, signs=5'b00001 (par=1).
  - Required: k3 = {1,4}; k0, k1, k2, k4 all = {0,0}, with sign forced to 0.
- Backpressure: basic frame, out_ready=0 for 3 cycles while k=1.
  - Required: out_data=9'h002, out_idx=1 held for 4 cycles; in_ready=0 throughout; then k2 = 9'h106.
- Back-to-back: second frame (min=4, min2=9, min_idx=0, signs=0) presented during the k4 beat of the first.
  - Required: accepted in that cycle; next cycle k0 = {0,8}; no idle cycle between frames.
- Pad index: min_idx=5, min=6, min2=2, signs=0.
  - Required: all five edges = {0,5}.
- Reset mid-frame: rst high for one cycle at k=2.
  - Required: next cycle out_valid=0, out_data=0, out_idx=0, in_ready=1; the remaining edges are never emitted.
